// File: rtl/clint_unit.sv
// Core-local interrupter: msip/mtimecmp/mtime registers behind a one-outstanding
// load/store port, plus raw timer, software and synchronised external pending lines.
module clint_unit #(
  parameter logic [31:0] BASE     = 32'h0200_0000,
  parameter int unsigned TICK_DIV = 1,
  parameter int unsigned SYNC_FF  = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [63:0] req_wdata,
  input  logic [7:0]  req_strobe,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [63:0] resp_rdata,
  output logic        resp_err,
  input  logic        ext_irq,
  output logic        trint,
  output logic        swint,
  output logic        exint
);

  localparam logic [31:0] MSIP_ADDR     = BASE;
  localparam logic [31:0] MTIMECMP_ADDR = BASE + 32'h0000_4000;
  localparam logic [31:0] MTIME_ADDR    = BASE + 32'h0000_BFF8;
  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESCALE_MAX = PW'(TICK_DIV - 1);

  // Handshake: a request transfers on a cycle where req_valid & req_ready are both
  // high; a response transfers on resp_valid & resp_ready. Only one transaction is
  // ever outstanding, so req_ready is exactly the complement of resp_valid.
  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RESP = 1'b1
  } state_e;

  state_e        state_q, state_d;
  logic          req_ready_q, req_ready_d;
  logic          resp_valid_q, resp_valid_d;
  logic [63:0]   resp_rdata_q, resp_rdata_d;
  logic          resp_err_q, resp_err_d;
  logic [63:0]   mtime_q, mtime_d;
  logic [63:0]   mtimecmp_q, mtimecmp_d;
  logic          msip_q, msip_d;
  logic [PW-1:0] prescale_q, prescale_d;
  logic          trint_q, trint_d;
  logic          swint_q, swint_d;
  logic [SYNC_FF-1:0] sync_q, sync_d;

  logic        accept;
  logic        aligned;
  logic        hit_msip;
  logic        hit_cmp;
  logic        hit_time;
  logic        addr_err;
  logic        reg_wr;
  logic        tick;
  logic [63:0] read_data;

  function automatic logic [63:0] merge_bytes(input logic [63:0] old_v,
                                              input logic [63:0] new_v,
                                              input logic [7:0]  strobe);
    logic [63:0] r;
    r = old_v;
    for (int b = 0; b < 8; b++) begin
      if (strobe[b]) r[8*b +: 8] = new_v[8*b +: 8];
    end
    return r;
  endfunction

  always_comb begin
    accept   = req_valid & req_ready_q;
    aligned  = (req_addr[2:0] == 3'b000);
    hit_msip = aligned & (req_addr == MSIP_ADDR);
    hit_cmp  = aligned & (req_addr == MTIMECMP_ADDR);
    hit_time = aligned & (req_addr == MTIME_ADDR);
    addr_err = ~(hit_msip | hit_cmp | hit_time);
    reg_wr   = accept & req_write & ~addr_err;
    tick     = (prescale_q == PRESCALE_MAX);

    read_data = 64'd0;
    if (hit_msip)      read_data = {63'd0, msip_q};
    else if (hit_cmp)  read_data = mtimecmp_q;
    else if (hit_time) read_data = mtime_q;
  end

  // Timer datapath; a store to mtime replaces the increment of a coincident tick.
  always_comb begin
    prescale_d = tick ? '0 : prescale_q + PW'(1);

    mtime_d = mtime_q;
    if (reg_wr && hit_time) mtime_d = merge_bytes(mtime_q, req_wdata, req_strobe);
    else if (tick)          mtime_d = mtime_q + 64'd1;

    mtimecmp_d = mtimecmp_q;
    if (reg_wr && hit_cmp) mtimecmp_d = merge_bytes(mtimecmp_q, req_wdata, req_strobe);

    msip_d = msip_q;
    if (reg_wr && hit_msip && req_strobe[0]) msip_d = req_wdata[0];

    trint_d = (mtime_d >= mtimecmp_d);
    swint_d = msip_d;
    sync_d  = {sync_q[SYNC_FF-2:0], ext_irq};
  end

  always_comb begin
    state_d      = state_q;
    req_ready_d  = req_ready_q;
    resp_valid_d = resp_valid_q;
    resp_rdata_d = resp_rdata_q;
    resp_err_d   = resp_err_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d      = ST_RESP;
          req_ready_d  = 1'b0;
          resp_valid_d = 1'b1;
          resp_rdata_d = (!req_write && !addr_err) ? read_data : 64'd0;
          resp_err_d   = addr_err;
        end
      end
      ST_RESP: begin
        if (resp_ready) begin
          state_d      = ST_IDLE;
          req_ready_d  = 1'b1;
          resp_valid_d = 1'b0;
        end
      end
      default: begin
        state_d      = ST_IDLE;
        req_ready_d  = 1'b1;
        resp_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= 64'd0;
      resp_err_q   <= 1'b0;
      mtime_q      <= 64'd0;
      mtimecmp_q   <= '1;
      msip_q       <= 1'b0;
      prescale_q   <= '0;
      trint_q      <= 1'b0;
      swint_q      <= 1'b0;
      sync_q       <= '0;
    end else begin
      state_q      <= state_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
      mtime_q      <= mtime_d;
      mtimecmp_q   <= mtimecmp_d;
      msip_q       <= msip_d;
      prescale_q   <= prescale_d;
      trint_q      <= trint_d;
      swint_q      <= swint_d;
      sync_q       <= sync_d;
    end
  end

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;
  assign trint      = trint_q;
  assign swint      = swint_q;
  assign exint      = sync_q[SYNC_FF-1];

  a_one_outstanding: assert property (@(posedge clk) disable iff (reset)
    req_ready_q ^ resp_valid_q);

  a_resp_stable: assert property (@(posedge clk) disable iff (reset)
    (resp_valid_q && !resp_ready) |=>
      (resp_valid_q && $stable(resp_rdata_q) && $stable(resp_err_q)));

endmodule

// File: tb/tb_clint_unit.sv
// Bench for clint_unit: two instances (TICK_DIV 1 and 4) share stimulus and are
// checked against a closed-form register/timer model through per-instance queues.
module tb_clint_unit;

  localparam logic [31:0] BASE   = 32'h0200_0000;
  localparam logic [31:0] A_MSIP = BASE;
  localparam logic [31:0] A_CMP  = BASE + 32'h0000_4000;
  localparam logic [31:0] A_TIME = BASE + 32'h0000_BFF8;

  // clock / reset
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic        req_valid = 1'b0;
  logic        req_write = 1'b0;
  logic [31:0] req_addr = 32'd0;
  logic [63:0] req_wdata = 64'd0;
  logic [7:0]  req_strobe = 8'd0;
  logic        resp_ready = 1'b1;
  logic        ext_irq = 1'b0;

  logic        req_ready_o  [2];
  logic        resp_valid_o [2];
  logic [63:0] resp_rdata_o [2];
  logic        resp_err_o   [2];
  logic        trint_o      [2];
  logic        swint_o      [2];
  logic        exint_o      [2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    clint_unit #(.BASE(BASE), .TICK_DIV((g == 0) ? 1 : 4), .SYNC_FF(2)) u_dut (
      .clk        (clk),
      .reset      (reset),
      .req_valid  (req_valid),
      .req_ready  (req_ready_o[g]),
      .req_write  (req_write),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .req_strobe (req_strobe),
      .resp_valid (resp_valid_o[g]),
      .resp_ready (resp_ready),
      .resp_rdata (resp_rdata_o[g]),
      .resp_err   (resp_err_o[g]),
      .ext_irq    (ext_irq),
      .trint      (trint_o[g]),
      .swint      (swint_o[g]),
      .exint      (exint_o[g])
    );
  end

  int n_tests = 0;
  int n_fail  = 0;

  // reference model state
  longint unsigned edge_cnt  = 0;
  longint unsigned base_edge = 0;
  logic [63:0]     base_t [2];
  logic [63:0]     cmp_m;
  logic            msip_m;
  logic            outstanding;
  logic            ext_hist [$];
  logic [64:0]     exp_q0 [$];
  logic [64:0]     exp_q1 [$];
  bit              mon_en = 1'b0;

  int  resp_mode = 0;
  bit  ext_rand  = 1'b0;

  function automatic longint unsigned td(input int i);
    return (i == 0) ? 64'd1 : 64'd4;
  endfunction

  // mtime after n counted edges: last stored value plus whole ticks since then
  function automatic logic [63:0] mtime_m(input int i, input longint unsigned n);
    return base_t[i] + 64'(n / td(i)) - 64'(base_edge / td(i));
  endfunction

  function automatic logic [63:0] merge_m(input logic [63:0] old_v, input logic [63:0] new_v,
                                          input logic [7:0] strobe);
    logic [63:0] mask;
    mask = 64'd0;
    for (int b = 0; b < 8; b++) if (strobe[b]) mask = mask | (64'hFF << (8 * b));
    return (old_v & ~mask) | (new_v & mask);
  endfunction

  task automatic check(input string name, input int i, input logic [64:0] act,
                       input logic [64:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d: got %h expected %h", name, i, act, exp);
    end
  endtask

  task automatic model_access();
    logic hit_m, hit_c, hit_t, err;
    logic [64:0] r [2];
    logic [63:0] new_t [2];
    hit_m = (req_addr == A_MSIP);
    hit_c = (req_addr == A_CMP);
    hit_t = (req_addr == A_TIME);
    err   = (req_addr[2:0] != 3'b000) || !(hit_m || hit_c || hit_t);
    for (int i = 0; i < 2; i++) begin
      if (err)             r[i] = {1'b1, 64'd0};
      else if (req_write)  r[i] = 65'd0;
      else if (hit_m)      r[i] = {1'b0, 63'd0, msip_m};
      else if (hit_c)      r[i] = {1'b0, cmp_m};
      else                 r[i] = {1'b0, mtime_m(i, edge_cnt)};
      new_t[i] = merge_m(mtime_m(i, edge_cnt), req_wdata, req_strobe);
    end
    exp_q0.push_back(r[0]);
    exp_q1.push_back(r[1]);
    if (req_write && !err) begin
      if (hit_m && req_strobe[0]) msip_m = req_wdata[0];
      if (hit_c) cmp_m = merge_m(cmp_m, req_wdata, req_strobe);
      if (hit_t) begin
        base_t[0] = new_t[0];
        base_t[1] = new_t[1];
        base_edge = edge_cnt + 1;
      end
    end
  endtask

  // model advances on every rising edge
  initial begin
    forever begin
      @(posedge clk);
      if (reset) begin
        edge_cnt = 0; base_edge = 0;
        base_t[0] = 64'd0; base_t[1] = 64'd0;
        cmp_m = '1; msip_m = 1'b0; outstanding = 1'b0;
        exp_q0.delete(); exp_q1.delete(); ext_hist.delete();
        mon_en = 1'b1;
      end else begin
        if (outstanding) begin
          if (resp_ready) outstanding = 1'b0;
        end else if (req_valid) begin
          model_access();
          outstanding = 1'b1;
        end
        ext_hist.push_back(ext_irq);
        if (ext_hist.size() > 4) void'(ext_hist.pop_front());
        edge_cnt++;
      end
    end
  end

  // monitor / scoreboard on the falling edge
  initial begin
    logic exp_ext;
    logic [64:0] front;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        exp_ext = (ext_hist.size() >= 2) ? ext_hist[ext_hist.size() - 2] : 1'b0;
        for (int i = 0; i < 2; i++) begin
          check("trint", i, 65'(trint_o[i]), 65'(mtime_m(i, edge_cnt) >= cmp_m));
          check("swint", i, 65'(swint_o[i]), 65'(msip_m));
          check("exint", i, 65'(exint_o[i]), 65'(exp_ext));
          check("req_ready", i, 65'(req_ready_o[i]), 65'(!outstanding));
          check("resp_valid", i, 65'(resp_valid_o[i]), 65'(outstanding));
          if (resp_valid_o[i]) begin
            if ((i == 0 ? exp_q0.size() : exp_q1.size()) == 0) begin
              n_tests++; n_fail++;
              $display("FAIL resp_unexpected dut%0d: got %h expected none", i,
                       {resp_err_o[i], resp_rdata_o[i]});
            end else begin
              front = (i == 0) ? exp_q0[0] : exp_q1[0];
              check("resp", i, {resp_err_o[i], resp_rdata_o[i]}, front);
              if (resp_ready) begin
                if (i == 0) void'(exp_q0.pop_front());
                else        void'(exp_q1.pop_front());
              end
            end
          end
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk); #1;
      case (resp_mode)
        0:       resp_ready = 1'b1;
        1:       resp_ready = 1'($urandom_range(0, 1));
        default: resp_ready = 1'b0;
      endcase
      if (ext_rand) ext_irq = 1'($urandom_range(0, 1));
    end
  end

  // driver tasks (called at posedge + 2)
  task automatic step();
    @(posedge clk); #2;
  endtask

  task automatic do_req(input logic wr, input logic [31:0] addr, input logic [63:0] wdata,
                        input logic [7:0] strobe);
    int n;
    n = 0;
    req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wdata; req_strobe = strobe;
    while (!req_ready_o[0] && n < 100) begin step(); n++; end
    if (n >= 100) begin
      n_tests++; n_fail++;
      $display("FAIL req_accept_timeout dut0: got req_ready=0 expected 1 within 100 cycles");
    end
    step();
    req_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (outstanding && n < 100) begin step(); n++; end
    if (n >= 100) begin
      n_tests++; n_fail++;
      $display("FAIL drain_timeout dut0: got outstanding=1 expected 0 within 100 cycles");
    end
  endtask

  task automatic check_reset_outputs();
    for (int i = 0; i < 2; i++) begin
      check("rst_resp_valid", i, 65'(resp_valid_o[i]), 65'd0);
      check("rst_resp_rdata", i, 65'(resp_rdata_o[i]), 65'd0);
      check("rst_resp_err",   i, 65'(resp_err_o[i]),   65'd0);
      check("rst_req_ready",  i, 65'(req_ready_o[i]),  65'd1);
      check("rst_irqs", i, 65'({trint_o[i], swint_o[i], exint_o[i]}), 65'd0);
    end
  endtask

  initial begin
    logic [31:0] addrs [6];
    logic [63:0] wd;
    logic [7:0]  sb;
    addrs[0] = A_MSIP; addrs[1] = A_CMP; addrs[2] = A_TIME;
    addrs[3] = BASE + 32'h0000_4004; addrs[4] = BASE + 32'h0000_1000; addrs[5] = BASE + 32'h0000_BFFC;

    repeat (3) @(posedge clk);
    #2;
    reset = 1'b0;
    check_reset_outputs();

    // timer compare crossing, then disarm
    do_req(1'b1, A_CMP, 64'd10, 8'hFF);
    repeat (20) step();
    for (int i = 0; i < 2; i++) check("trint_after_cross", i, 65'(trint_o[i]), 65'(i == 0));
    do_req(1'b1, A_CMP, '1, 8'hFF);
    repeat (2) step();

    // msip: only bit 0 is stored
    do_req(1'b1, A_MSIP, '1, 8'hFF);
    do_req(1'b0, A_MSIP, 64'd0, 8'h00);
    do_req(1'b1, A_MSIP, 64'd0, 8'hFF);
    do_req(1'b1, A_MSIP, 64'd1, 8'h00);

    // mtime wrap and stores landing on every prescaler phase
    do_req(1'b1, A_TIME, 64'hFFFF_FFFF_FFFF_FFFE, 8'hFF);
    repeat (10) step();
    do_req(1'b0, A_TIME, 64'd0, 8'h00);
    for (int k = 0; k < 4; k++) begin
      repeat (k) step();
      do_req(1'b1, A_TIME, 64'(k * 100), 8'hFF);
      do_req(1'b0, A_TIME, 64'd0, 8'h00);
    end
    do_req(1'b1, A_TIME, 64'h1122_3344_5566_7788, 8'b1010_0101);
    do_req(1'b0, A_TIME, 64'd0, 8'h00);

    // unmapped, misaligned, and zero-strobe accesses
    do_req(1'b1, BASE + 32'h0000_1000, 64'hDEAD_BEEF_0000_0001, 8'hFF);
    do_req(1'b0, BASE + 32'h0000_4004, 64'd0, 8'h00);
    do_req(1'b1, A_CMP, 64'h0123_4567_89AB_CDEF, 8'h00);
    do_req(1'b0, A_CMP, 64'd0, 8'h00);
    do_req(1'b0, A_MSIP, 64'd0, 8'h00);

    // stalled response
    resp_mode = 2;
    do_req(1'b0, A_CMP, 64'd0, 8'h00);
    repeat (5) step();
    resp_mode = 0;
    do_req(1'b0, A_TIME, 64'd0, 8'h00);
    drain();

    // one-cycle external pulse
    ext_irq = 1'b1;
    step();
    ext_irq = 1'b0;
    repeat (4) step();

    // reset while a response is pending
    do_req(1'b1, A_MSIP, 64'd1, 8'h01);
    resp_mode = 2;
    do_req(1'b0, A_TIME, 64'd0, 8'h00);
    step();
    reset = 1'b1;
    step();
    check_reset_outputs();
    reset = 1'b0;
    resp_mode = 0;
    step();

    // randomized traffic
    ext_rand = 1'b1;
    resp_mode = 1;
    for (int t = 0; t < 250; t++) begin
      wd = {$urandom, $urandom};
      if ($urandom_range(0, 2) == 0) wd = 64'($urandom_range(0, 400));
      if ($urandom_range(0, 5) == 0) wd = 64'hFFFF_FFFF_FFFF_FFF0 + 64'($urandom_range(0, 15));
      sb = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 1) == 0) sb = 8'hFF;
      do_req(1'($urandom_range(0, 1)), addrs[$urandom_range(0, 5)], wd, sb);
      repeat ($urandom_range(0, 2)) step();
    end
    resp_mode = 0;
    ext_rand = 1'b0;
    drain();
    repeat (3) step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
